// File: rtl/jt900h_ramfetch.sv
// Multi-channel byte-granular fetch unit over one shared 16-bit little-endian RAM port.
// A one-halfword reuse buffer skips re-reading the halfword shared by sequential fetches.
module jt900h_ramfetch #(
   parameter int unsigned NCH  = 2,
   parameter int unsigned AW   = 24,
   parameter int unsigned OUTW = 4,
   parameter int unsigned RR   = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cen,
   input  logic [NCH-1:0]    req,
   input  logic [NCH*AW-1:0] addr,
   input  logic              inv,
   output logic [AW-1:0]     ram_addr,
   output logic              ram_cs,
   input  logic [15:0]       ram_dout,
   output logic [8*OUTW-1:0] dout,
   output logic [NCH-1:0]    rdy
);
   localparam int unsigned CW     = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned K_EVEN = (OUTW + 1) / 2;
   localparam int unsigned K_ODD  = (OUTW + 2) / 2;
   localparam int unsigned IW     = $clog2(K_ODD + 1);
   localparam int unsigned ASMW   = 16 * K_ODD;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_READ = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [CW-1:0]     ch_q, ch_d;
   logic              odd_q, odd_d;
   logic [IW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [ASMW-1:0]   asm_q, asm_d;
   logic              inv_seen_q, inv_seen_d;
   logic              buf_valid_q, buf_valid_d;
   logic [AW-1:0]     buf_addr_q, buf_addr_d;
   logic [15:0]       buf_data_q, buf_data_d;
   logic [CW-1:0]     rr_q, rr_d;
   logic [AW-1:0]     ram_addr_q, ram_addr_d;
   logic              ram_cs_q, ram_cs_d;
   logic [8*OUTW-1:0] dout_q, dout_d;
   logic [NCH-1:0]    rdy_q, rdy_d;

   logic              gnt_valid;
   logic [CW-1:0]     gnt_ch;
   logic [AW-1:0]     gnt_addr;
   logic [AW-1:0]     gnt_h0;
   logic [IW-1:0]     gnt_k;
   logic              gnt_hit;
   logic [ASMW-1:0]   asm_cap;
   logic [ASMW-1:0]   asm_fin;
   logic [ASMW-1:0]   asm_shift;

   // i-th candidate in search order: fixed from 0, or rotating from the channel after rr_q
   function automatic logic [CW-1:0] cand(input logic [CW-1:0] ptr, input int unsigned i);
      int unsigned c;
      if (RR != 0) c = (32'(ptr) + 32'd1 + i) % NCH;
      else         c = i;
      return CW'(c);
   endfunction

   // Arbitration and per-grant address setup
   always_comb begin
      gnt_valid = 1'b0;
      gnt_ch    = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (!gnt_valid && req[cand(rr_q, i)]) begin
            gnt_valid = 1'b1;
            gnt_ch    = cand(rr_q, i);
         end
      end
      gnt_addr = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (gnt_ch == CW'(i)) gnt_addr = addr[i*AW +: AW];
      end
      gnt_h0  = {gnt_addr[AW-1:1], 1'b0};
      gnt_k   = gnt_addr[0] ? IW'(K_ODD) : IW'(K_EVEN);
      gnt_hit = buf_valid_q && !inv && (buf_addr_q == gnt_h0);
   end

   // Assembly with the current RAM halfword merged in, then byte-aligned
   always_comb begin
      asm_cap = asm_q;
      for (int unsigned j = 0; j < K_ODD; j++) begin
         if (idx_q == IW'(j)) asm_cap[j*16 +: 16] = ram_dout;
      end
      asm_fin   = (cnt_q == '0) ? asm_q : asm_cap;
      asm_shift = odd_q ? (asm_fin >> 8) : asm_fin;
   end

   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      odd_d       = odd_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      asm_d       = asm_q;
      inv_seen_d  = inv_seen_q;
      buf_valid_d = buf_valid_q;
      buf_addr_d  = buf_addr_q;
      buf_data_d  = buf_data_q;
      rr_d        = rr_q;
      ram_addr_d  = ram_addr_q;
      ram_cs_d    = ram_cs_q;
      dout_d      = dout_q;
      rdy_d       = rdy_q;
      if (cen) begin
         rdy_d = '0;
         if (inv) begin
            buf_valid_d = 1'b0;
            inv_seen_d  = 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (gnt_valid) begin
                  ch_d       = gnt_ch;
                  rr_d       = gnt_ch;
                  odd_d      = gnt_addr[0];
                  inv_seen_d = inv;
                  asm_d      = '0;
                  state_d    = ST_READ;
                  if (gnt_hit) begin
                     asm_d[15:0] = buf_data_q;
                     idx_d       = IW'(1);
                     cnt_d       = gnt_k - IW'(1);
                     ram_addr_d  = gnt_h0 + AW'(2);
                     ram_cs_d    = (gnt_k != IW'(1));
                  end else begin
                     idx_d      = '0;
                     cnt_d      = gnt_k;
                     ram_addr_d = gnt_h0;
                     ram_cs_d   = 1'b1;
                  end
               end
            end
            ST_READ: begin
               if (cnt_q != '0) begin
                  asm_d = asm_cap;
                  idx_d = idx_q + IW'(1);
                  cnt_d = cnt_q - IW'(1);
                  if (cnt_q != IW'(1)) ram_addr_d = ram_addr_q + AW'(2);
               end
               // Last capture, or a fetch fully served by the reuse buffer
               if (cnt_q <= IW'(1)) begin
                  ram_cs_d = 1'b0;
                  dout_d   = asm_shift[8*OUTW-1:0];
                  rdy_d    = NCH'(1) << ch_q;
                  state_d  = ST_DONE;
                  if (cnt_q == IW'(1)) begin
                     buf_addr_d  = ram_addr_q;
                     buf_data_d  = ram_dout;
                     buf_valid_d = !(inv_seen_q || inv);
                  end
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ch_q        <= '0;
         odd_q       <= 1'b0;
         cnt_q       <= '0;
         idx_q       <= '0;
         asm_q       <= '0;
         inv_seen_q  <= 1'b0;
         buf_valid_q <= 1'b0;
         buf_addr_q  <= '0;
         buf_data_q  <= '0;
         rr_q        <= CW'(NCH - 1);
         ram_addr_q  <= '0;
         ram_cs_q    <= 1'b0;
         dout_q      <= '0;
         rdy_q       <= '0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         odd_q       <= odd_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         asm_q       <= asm_d;
         inv_seen_q  <= inv_seen_d;
         buf_valid_q <= buf_valid_d;
         buf_addr_q  <= buf_addr_d;
         buf_data_q  <= buf_data_d;
         rr_q        <= rr_d;
         ram_addr_q  <= ram_addr_d;
         ram_cs_q    <= ram_cs_d;
         dout_q      <= dout_d;
         rdy_q       <= rdy_d;
      end
   end

   assign ram_addr = ram_addr_q;
   assign ram_cs   = ram_cs_q;
   assign dout     = dout_q;
   assign rdy      = rdy_q;
endmodule

// File: tb/tb_jt900h_ramfetch.sv
// Directed bench for jt900h_ramfetch: fixed-priority instance (a) and round-robin instance (b),
// both backed by a RAM whose byte i holds i & 0xFF.
`timescale 1ns/1ps
module tb_jt900h_ramfetch;
   localparam int unsigned NCH  = 2;
   localparam int unsigned AW   = 24;
   localparam int unsigned OUTW = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cen;
   logic              inv;
   logic              inv_b;
   logic [NCH-1:0]    req_a, req_b;
   logic [NCH*AW-1:0] addr_a, addr_b;
   logic [AW-1:0]     ram_addr_a, ram_addr_b;
   logic              ram_cs_a, ram_cs_b;
   logic [15:0]       ram_dout_a, ram_dout_b;
   logic [8*OUTW-1:0] dout_a, dout_b;
   logic [NCH-1:0]    rdy_a, rdy_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   function automatic logic [15:0] ram_word(input logic [AW-1:0] a);
      logic [7:0] lo;
      lo = a[7:0];
      return {lo + 8'd1, lo};
   endfunction

   function automatic logic [31:0] exp_word(input logic [AW-1:0] a);
      logic [7:0] b;
      b = a[7:0];
      return {b + 8'd3, b + 8'd2, b + 8'd1, b};
   endfunction

   assign ram_dout_a = ram_word(ram_addr_a);
   assign ram_dout_b = ram_word(ram_addr_b);

   jt900h_ramfetch #(.NCH(NCH), .AW(AW), .OUTW(OUTW), .RR(0)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .cen(cen), .req(req_a), .addr(addr_a), .inv(inv),
      .ram_addr(ram_addr_a), .ram_cs(ram_cs_a), .ram_dout(ram_dout_a),
      .dout(dout_a), .rdy(rdy_a));

   jt900h_ramfetch #(.NCH(NCH), .AW(AW), .OUTW(OUTW), .RR(1)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .cen(cen), .req(req_b), .addr(addr_b), .inv(inv_b),
      .ram_addr(ram_addr_b), .ram_cs(ram_cs_b), .ram_dout(ram_dout_b),
      .dout(dout_b), .rdy(rdy_b));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Requests one fetch on instance a and reports data, cycles to rdy, reads and first read address
   task automatic run_fetch(input int ch, input logic [AW-1:0] a, input bit drop,
                            output logic [31:0] d, output int lat, output int reads,
                            output logic [AW-1:0] first_ra);
      req_a[ch] = 1'b1;
      addr_a[ch*AW +: AW] = a;
      lat = 0;
      reads = 0;
      first_ra = '1;
      do begin
         tick();
         lat++;
         if (ram_cs_a) begin
            if (reads == 0) first_ra = ram_addr_a;
            reads++;
         end
      end while (!rdy_a[ch] && lat < 20);
      d = dout_a;
      if (drop) begin
         req_a[ch] = 1'b0;
         tick();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cen = 1'b1; inv = 1'b0; inv_b = 1'b0;
      req_a = '0; req_b = '0; addr_a = '0; addr_b = '0;
      repeat (3) tick();
      n_checks++; if (ram_cs_a !== 1'b0)   begin n_fail++; $display("FAIL reset_ram_cs: got %b expected 0", ram_cs_a); end
      n_checks++; if (ram_addr_a !== 24'h0) begin n_fail++; $display("FAIL reset_ram_addr: got %h expected 000000", ram_addr_a); end
      n_checks++; if (dout_a !== 32'h0)     begin n_fail++; $display("FAIL reset_dout: got %h expected 00000000", dout_a); end
      n_checks++; if (rdy_a !== 2'b00)      begin n_fail++; $display("FAIL reset_rdy: got %b expected 00", rdy_a); end
      n_checks++; if (rdy_b !== 2'b00 || ram_cs_b !== 1'b0) begin n_fail++; $display("FAIL reset_b: rdy %b cs %b expected 00 0", rdy_b, ram_cs_b); end
      rst_n = 1'b1;
      repeat (2) tick();
      n_checks++; if (ram_cs_a !== 1'b0 || rdy_a !== 2'b00) begin n_fail++; $display("FAIL idle_no_req: cs %b rdy %b expected 0 00", ram_cs_a, rdy_a); end
   endtask

   task automatic test_stream_even();
      logic [31:0] d; int lat; int reads; logic [AW-1:0] fra; logic [AW-1:0] a;
      for (int i = 0; i < 256; i++) begin
         a = AW'(4 * i);
         run_fetch(0, a, (i == 255), d, lat, reads, fra);
         n_checks++; if (d !== exp_word(a)) begin n_fail++; $display("FAIL even_data @%h: got %h expected %h", a, d, exp_word(a)); end
         n_checks++; if (lat != ((i == 0) ? 3 : 4)) begin n_fail++; $display("FAIL even_period @%h: got %0d expected %0d", a, lat, (i == 0) ? 3 : 4); end
         n_checks++; if (reads != 2) begin n_fail++; $display("FAIL even_reads @%h: got %0d expected 2", a, reads); end
      end
   endtask

   task automatic test_stream_odd();
      logic [31:0] d; int lat; int reads; logic [AW-1:0] fra; logic [AW-1:0] a;
      for (int i = 0; i < 8; i++) begin
         a = AW'(1 + 4 * i);
         run_fetch(0, a, (i == 7), d, lat, reads, fra);
         n_checks++; if (d !== exp_word(a)) begin n_fail++; $display("FAIL odd_data @%h: got %h expected %h", a, d, exp_word(a)); end
         n_checks++; if (lat != 4) begin n_fail++; $display("FAIL odd_latency @%h: got %0d expected 4", a, lat); end
         n_checks++; if (reads != ((i == 0) ? 3 : 2)) begin n_fail++; $display("FAIL odd_reads @%h: got %0d expected %0d", a, reads, (i == 0) ? 3 : 2); end
         n_checks++; if (fra !== ((i == 0) ? 24'h0 : a + 24'h1)) begin n_fail++; $display("FAIL odd_first_addr @%h: got %h", a, fra); end
      end
   endtask

   task automatic test_cen_freeze();
      req_a[0] = 1'b1;
      addr_a[0 +: AW] = 24'h000100;
      tick();
      n_checks++; if (ram_cs_a !== 1'b1 || ram_addr_a !== 24'h000100) begin n_fail++; $display("FAIL cen_first_read: cs %b addr %h expected 1 000100", ram_cs_a, ram_addr_a); end
      cen = 1'b0;
      repeat (3) tick();
      n_checks++; if (ram_cs_a !== 1'b1 || ram_addr_a !== 24'h000100 || rdy_a !== 2'b00) begin n_fail++; $display("FAIL cen_frozen: cs %b addr %h rdy %b expected 1 000100 00", ram_cs_a, ram_addr_a, rdy_a); end
      cen = 1'b1;
      tick();
      n_checks++; if (ram_addr_a !== 24'h000102) begin n_fail++; $display("FAIL cen_second_read: got %h expected 000102", ram_addr_a); end
      tick();
      n_checks++; if (rdy_a !== 2'b01 || dout_a !== 32'h03020100) begin n_fail++; $display("FAIL cen_result: rdy %b dout %h expected 01 03020100", rdy_a, dout_a); end
      req_a[0] = 1'b0;
      tick();
   endtask

   task automatic test_same_cycle();
      int t;
      req_a = 2'b11;
      addr_a = {24'h000020, 24'h000010};
      t = 0;
      do begin tick(); t++; end while (rdy_a == 2'b00 && t < 20);
      n_checks++; if (rdy_a !== 2'b01 || t != 3) begin n_fail++; $display("FAIL prio_first: rdy %b after %0d expected 01 after 3", rdy_a, t); end
      n_checks++; if (dout_a !== 32'h13121110) begin n_fail++; $display("FAIL prio_data0: got %h expected 13121110", dout_a); end
      req_a[0] = 1'b0;
      t = 0;
      do begin tick(); t++; end while (rdy_a == 2'b00 && t < 20);
      n_checks++; if (rdy_a !== 2'b10 || t != 4) begin n_fail++; $display("FAIL prio_second: rdy %b after %0d expected 10 after 4", rdy_a, t); end
      n_checks++; if (dout_a !== 32'h23222120) begin n_fail++; $display("FAIL prio_data1: got %h expected 23222120", dout_a); end
      req_a[1] = 1'b0;
      repeat (2) tick();
      n_checks++; if (dout_a !== 32'h23222120 || rdy_a !== 2'b00) begin n_fail++; $display("FAIL dout_hold: dout %h rdy %b expected 23222120 00", dout_a, rdy_a); end
   endtask

   task automatic test_round_robin();
      int t; logic [1:0] exp_rdy; logic [31:0] exp_d;
      req_b = 2'b11;
      addr_b = {24'h000051, 24'h000040};
      exp_rdy = 2'b01;
      for (int p = 0; p < 6; p++) begin
         t = 0;
         do begin tick(); t++; end while (rdy_b == 2'b00 && t < 20);
         exp_d = exp_rdy[0] ? 32'h43424140 : 32'h54535251;
         n_checks++; if (rdy_b !== exp_rdy) begin n_fail++; $display("FAIL rr_grant #%0d: got %b expected %b", p, rdy_b, exp_rdy); end
         n_checks++; if (dout_b !== exp_d) begin n_fail++; $display("FAIL rr_data #%0d: got %h expected %h", p, dout_b, exp_d); end
         exp_rdy = ~exp_rdy;
      end
      req_b = '0;
      repeat (2) tick();
   endtask

   task automatic test_invalidate();
      logic [31:0] d; int lat; int reads; logic [AW-1:0] fra;
      run_fetch(0, 24'h000003, 1'b1, d, lat, reads, fra);
      n_checks++; if (d !== 32'h06050403 || reads != 3) begin n_fail++; $display("FAIL inv_pre: dout %h reads %0d expected 06050403 3", d, reads); end
      run_fetch(0, 24'h000007, 1'b1, d, lat, reads, fra);
      n_checks++; if (reads != 2 || fra !== 24'h000008 || lat != 3) begin n_fail++; $display("FAIL reuse_hit: reads %0d first %h lat %0d expected 2 000008 3", reads, fra, lat); end
      n_checks++; if (d !== 32'h0A090807) begin n_fail++; $display("FAIL reuse_data: got %h expected 0a090807", d); end
      run_fetch(0, 24'h000003, 1'b1, d, lat, reads, fra);
      inv = 1'b1;
      tick();
      inv = 1'b0;
      run_fetch(0, 24'h000007, 1'b1, d, lat, reads, fra);
      n_checks++; if (reads != 3 || fra !== 24'h000006) begin n_fail++; $display("FAIL inv_no_reuse: reads %0d first %h expected 3 000006", reads, fra); end
      n_checks++; if (d !== 32'h0A090807 || lat != 4) begin n_fail++; $display("FAIL inv_data: dout %h lat %0d expected 0a090807 4", d, lat); end
   endtask

   task automatic test_reset_abort();
      logic [31:0] d; int lat; int reads; logic [AW-1:0] fra;
      run_fetch(0, 24'hFFFFFD, 1'b1, d, lat, reads, fra);
      n_checks++; if (d !== 32'h00FFFEFD || reads != 3 || fra !== 24'hFFFFFC) begin n_fail++; $display("FAIL wrap: dout %h reads %0d first %h expected 00fffefd 3 fffffc", d, reads, fra); end
      req_a[0] = 1'b1;
      addr_a[0 +: AW] = 24'h000041;
      repeat (2) tick();
      n_checks++; if (ram_cs_a !== 1'b1 || ram_addr_a !== 24'h000042) begin n_fail++; $display("FAIL abort_pre: cs %b addr %h expected 1 000042", ram_cs_a, ram_addr_a); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (ram_cs_a !== 1'b0 || rdy_a !== 2'b00 || ram_addr_a !== 24'h0) begin n_fail++; $display("FAIL abort_async: cs %b rdy %b addr %h expected 0 00 000000", ram_cs_a, rdy_a, ram_addr_a); end
      req_a[0] = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      n_checks++; if (rdy_a !== 2'b00) begin n_fail++; $display("FAIL abort_no_rdy: got %b expected 00", rdy_a); end
      run_fetch(0, 24'h000001, 1'b1, d, lat, reads, fra);
      n_checks++; if (reads != 3 || fra !== 24'h0 || lat != 4) begin n_fail++; $display("FAIL post_reset_reads: reads %0d first %h lat %0d expected 3 000000 4", reads, fra, lat); end
      n_checks++; if (d !== 32'h04030201) begin n_fail++; $display("FAIL post_reset_data: got %h expected 04030201", d); end
   endtask

   initial begin
      test_reset();
      test_stream_even();
      test_stream_odd();
      test_cen_freeze();
      test_same_cycle();
      test_round_robin();
      test_invalidate();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/jt900h_ramfetch.md
# jt900h_ramfetch

Parametrised multi-channel RAM fetch unit for the jt900h core. It serves NCH independent requesters, such as the instruction fetcher on channel 0 and the data/index path on channel 1, over one shared 16-bit little-endian RAM port. Each request returns OUTW bytes starting at an arbitrary, possibly odd, byte address. A one-halfword reuse buffer avoids re-reading the halfword shared by consecutive sequential fetches.

## Interface
Parameters:
- NCH, 2: number of requesting channels (1..8); channel 0 is lowest index.
- AW, 24: byte address width.
- OUTW, 4: bytes returned per fetch (1..8).
- RR, 0: arbitration mode; 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cen  in  1  clock enable; all state advances only on clk edges with cen=1.
- req  in  NCH  per-channel request level; held high until that channel's rdy.
- addr  in  NCH*AW  per-channel byte address; channel i occupies bits [i*AW +: AW]; stable while req is high.
- inv  in  1  invalidates the reuse buffer (RAM was written elsewhere).
- ram_addr  out  AW  halfword-aligned byte address; bit 0 is always 0.
- ram_cs  out  1  high while a RAM read is in progress.
- ram_dout  in  16  RAM data for ram_addr, combinational; sampled at the end of the cycle; byte at ram_addr is in [7:0].
- dout  out  8*OUTW  fetched bytes; byte at the request address is in [7:0].
- rdy  out  NCH  one-cycle completion pulse for the granted channel.

## Operation
- FSM states: IDLE, READ, DONE.
- IDLE: if cen=1 and any req bit is high, grant one channel.
  - RR=0: the lowest-index requesting channel wins.
  - RR=1: search starts at the channel after the last granted one. The pointer resets to NCH-1, so channel 0 has first priority.
- On grant:
  - Latch the channel and its addr.
  - Compute the halfword count k = ceil((addr[0]+OUTW)/2).
  - Compute the first halfword address h0 = {addr[AW-1:1],1'b0}.
- Reuse check: if buf_valid=1 and buf_addr==h0, load buf_data as halfword 0 without a read and start reading at h0+2. k is decremented.
- READ: drive ram_addr = current halfword address and ram_cs=1. Capture ram_dout into the assembly register at each cen edge.
- Address wrap: the halfword address increments by 2 modulo 2^AW, so a fetch at 2^AW-1 reads 0xFFFFFE then 0x000000.
- After the last capture:
  - The last halfword and its address go into buf_data/buf_addr.
  - buf_valid is set unless inv was seen during this fetch.
  - Go to DONE.
- DONE: pulse rdy for the granted channel. dout = assembled bytes shifted right by 8*addr[0] and truncated to OUTW bytes. Return to IDLE.
- dout holds its value until the next DONE.
- inv=1 in any cycle clears buf_valid immediately and blocks the in-flight fetch from setting it.
- If req drops mid-fetch, the fetch still completes and rdy still pulses; the requester ignores it.
- A channel that keeps req high after rdy is treated as a new request in the next IDLE.
- cen=0 freezes all state and outputs.

## Timing
- Reset values:
  - State IDLE.
  - ram_addr=0, ram_cs=0, dout=0, rdy=0.
  - buf_valid=0, RR pointer=NCH-1.
- Grant is at cen edge N. ram_cs rises in cycle N+1, and the halfword reads occupy cycles N+1..N+k. rdy is high in cycle N+k+1.
- With OUTW=4, no reuse:
  - Even address: k=2, rdy at N+3.
  - Odd address: k=3, rdy at N+4.
- Reuse with odd address and OUTW=4: k=2, rdy at N+3.
- Reuse leaving k=0 (OUTW=1, odd address hit): no READ cycles, rdy at N+2.
- Back-to-back throughput is one fetch per k+2 cycles, because the IDLE cycle of the next grant coincides with DONE+1.
- rst_n low in any state returns to reset values asynchronously. No rdy is issued for the aborted fetch.

## Test plan
- RAM preloaded with buf[i]=i&0xFF; channel 0 streams addresses 0,4,8…1020 -> every rdy shows dout=={a+3,a+2,a+1,a}, e.g. 0x03020100 at a=0; rdy every 4 cycles.
- Channel 0 streams 1,5,9… -> first fetch reads halfwords 0,2,4 and returns 0x04030201. Later fetches reuse the buffer and read 2 halfwords, with rdy 3 cycles after grant.
- req=2'b11 in the same cycle, addresses 0x10 and 0x20, RR=0 -> channel 0 completes first with 0x13121110, then channel 1 with 0x23222120.
- RR=1, both channels requesting continuously -> grants alternate 0,1,0,1. Neither channel gets two consecutive rdy pulses.
- Fetch at 0x03 completes. Pulse inv, then fetch 0x07 -> no reuse: 3 RAM reads starting at ram_addr=0x06, data 0x0A090807.
- Assert rst_n low during the second READ cycle -> ram_cs=0, no rdy, buf_valid=0. After release, a fetch at 0x01 needs 3 reads.
